// File: rtl/load_store_unit_l8.sv
// load_store_unit_l8: load/store execute unit with a tagged completion buffer that retires in issue order.
// Define LSU_L8_ALIGN_CHECK_EN to fault misaligned H/W accesses instead of issuing them.
module load_store_unit_l8 #(
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6,
    parameter int p_opaq_bits      = 8,
    parameter int p_num_in_flight  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        d_val,
    output logic                        d_rdy,
    input  logic [2:0]                  d_uop,
    input  logic [31:0]                 d_op1,
    input  logic [31:0]                 d_op2,
    input  logic [31:0]                 d_op3,
    input  logic [p_seq_num_bits-1:0]   d_seq_num,
    input  logic [4:0]                  d_waddr,
    input  logic [p_phys_addr_bits-1:0] d_preg,
    input  logic [p_phys_addr_bits-1:0] d_ppreg,
    input  logic [31:0]                 d_pc,
    output logic                        w_val,
    input  logic                        w_rdy,
    output logic [31:0]                 w_wdata,
    output logic                        w_wen,
    output logic [4:0]                  w_waddr,
    output logic [p_phys_addr_bits-1:0] w_preg,
    output logic [p_phys_addr_bits-1:0] w_ppreg,
    output logic [p_seq_num_bits-1:0]   w_seq_num,
    output logic [31:0]                 w_pc,
    output logic                        mem_req_val,
    input  logic                        mem_req_rdy,
    output logic                        mem_req_type,
    output logic [31:0]                 mem_req_addr,
    output logic [31:0]                 mem_req_data,
    output logic [3:0]                  mem_req_strb,
    output logic [p_opaq_bits-1:0]      mem_req_opaque,
    input  logic                        mem_resp_val,
    output logic                        mem_resp_rdy,
    input  logic [p_opaq_bits-1:0]      mem_resp_opaque,
    input  logic [31:0]                 mem_resp_data,
    output logic                        misaligned
);
    localparam int IW = $clog2(p_num_in_flight);
    localparam int CW = IW + 1;
    // uop encoding; mem_req_type is 0 for read, 1 for write
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic                        dr_val;
    logic [2:0]                  dr_uop;
    logic [31:0]                 dr_op1, dr_op2, dr_op3, dr_pc;
    logic [p_seq_num_bits-1:0]   dr_seq;
    logic [4:0]                  dr_waddr;
    logic [p_phys_addr_bits-1:0] dr_preg, dr_ppreg;

    logic [p_num_in_flight-1:0]  e_valid, e_done, e_mis;
    logic [2:0]                  e_uop   [p_num_in_flight];
    logic [1:0]                  e_off   [p_num_in_flight];
    logic [31:0]                 e_data  [p_num_in_flight];
    logic [31:0]                 e_pc    [p_num_in_flight];
    logic [p_seq_num_bits-1:0]   e_seq   [p_num_in_flight];
    logic [4:0]                  e_waddr [p_num_in_flight];
    logic [p_phys_addr_bits-1:0] e_preg  [p_num_in_flight];
    logic [p_phys_addr_bits-1:0] e_ppreg [p_num_in_flight];
    logic [IW-1:0]               head, tail, r_idx;
    logic [CW-1:0]               count;

    logic [31:0] addr, sh;
    logic [1:0]  off;
    logic [3:0]  base;
    logic [2:0]  u;
    logic        is_b, is_h, mis, full, issue, w_xfer, resp_ok;

    assign addr  = dr_op1 + dr_op2;
    assign off   = addr[1:0];
    assign is_b  = dr_uop == LB || dr_uop == LBU || dr_uop == SB;
    assign is_h  = dr_uop == LH || dr_uop == LHU || dr_uop == SH;
    assign base  = is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111;
`ifdef LSU_L8_ALIGN_CHECK_EN
    assign mis   = (is_h && off[0]) || (!is_b && !is_h && off != 2'b00);
`else
    assign mis   = 1'b0;
`endif
    // full uses the registered count, so a slot freed this cycle is not reusable until next cycle
    assign full  = count == CW'(p_num_in_flight);
    assign issue = dr_val && !full && (mem_req_rdy || mis);
    assign d_rdy = !dr_val || issue;

    assign mem_req_val    = dr_val && !full && !mis;
    assign mem_req_type   = dr_uop >= SB;
    assign mem_req_addr   = {addr[31:2], 2'b00};
    assign mem_req_strb   = base << off;
    assign mem_req_data   = dr_op3 << {off, 3'b000};
    assign mem_req_opaque = p_opaq_bits'(tail);
    assign mem_resp_rdy   = 1'b1;

    assign r_idx   = mem_resp_opaque[IW-1:0];
    assign resp_ok = mem_resp_val && (mem_resp_opaque >> IW) == '0 && e_valid[r_idx] && !e_done[r_idx];

    assign u         = e_uop[head];
    assign sh        = e_data[head] >> {e_off[head], 3'b000};
    assign w_val     = e_valid[head] && e_done[head];
    assign w_xfer    = w_val && w_rdy;
    assign w_wen     = !e_mis[head] && u < SB;
    assign w_wdata   = u == LB  ? {{24{sh[7]}}, sh[7:0]} :
                       u == LH  ? {{16{sh[15]}}, sh[15:0]} :
                       u == LBU ? {24'b0, sh[7:0]} :
                       u == LHU ? {16'b0, sh[15:0]} : sh;
    assign w_waddr   = e_waddr[head];
    assign w_preg    = e_preg[head];
    assign w_ppreg   = e_ppreg[head];
    assign w_seq_num = e_seq[head];
    assign w_pc      = e_pc[head];
`ifdef LSU_L8_ALIGN_CHECK_EN
    assign misaligned = w_xfer && e_mis[head];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dr_val  <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
            e_done  <= '0;
        end else begin
            if (d_val && d_rdy) dr_val <= 1'b1;
            else if (issue) dr_val <= 1'b0;
            if (w_xfer) begin
                e_valid[head] <= 1'b0;
                head          <= head + IW'(1);
            end
            if (issue) begin
                e_valid[tail] <= 1'b1;
                e_done[tail]  <= mis;
                tail          <= tail + IW'(1);
            end
            if (resp_ok) e_done[r_idx] <= 1'b1;
            count <= count + CW'(issue) - CW'(w_xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (d_val && d_rdy) begin
            dr_uop   <= d_uop;
            dr_op1   <= d_op1;
            dr_op2   <= d_op2;
            dr_op3   <= d_op3;
            dr_seq   <= d_seq_num;
            dr_waddr <= d_waddr;
            dr_preg  <= d_preg;
            dr_ppreg <= d_ppreg;
            dr_pc    <= d_pc;
        end
        if (issue) begin
            e_uop[tail]   <= dr_uop;
            e_off[tail]   <= off;
            e_mis[tail]   <= mis;
            e_seq[tail]   <= dr_seq;
            e_waddr[tail] <= dr_waddr;
            e_preg[tail]  <= dr_preg;
            e_ppreg[tail] <= dr_ppreg;
            e_pc[tail]    <= dr_pc;
        end
        if (resp_ok) e_data[r_idx] <= mem_resp_data;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk)
        if (!rst && mem_resp_val && !resp_ok)
            $error("load_store_unit_l8: dropped response with tag %0d", mem_resp_opaque);
`endif
endmodule

// File: tb/tb_load_store_unit_l8.sv
// tb_load_store_unit_l8: directed scoreboard bench for load_store_unit_l8.
// Covers both builds of LSU_L8_ALIGN_CHECK_EN.
module tb_load_store_unit_l8;
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    typedef struct {
        logic        t;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        logic [7:0]  opq;
    } req_t;
    typedef struct {
        logic        chkd, wen, mis;
        logic [31:0] wdata;
        logic [48:0] meta;
    } w_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        d_val = 1'b0, d_rdy;
    logic [2:0]  d_uop = '0;
    logic [31:0] d_op1 = '0, d_op2 = '0, d_op3 = '0, d_pc = '0;
    logic [4:0]  d_seq_num = '0, d_waddr = '0;
    logic [5:0]  d_preg = '0, d_ppreg = '0;
    logic        w_val, w_rdy = 1'b1, w_wen;
    logic [31:0] w_wdata, w_pc;
    logic [4:0]  w_waddr, w_seq_num;
    logic [5:0]  w_preg, w_ppreg;
    logic        mem_req_val, mem_req_rdy = 1'b1, mem_req_type;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_strb;
    logic [7:0]  mem_req_opaque;
    logic        mem_resp_val = 1'b0, mem_resp_rdy;
    logic [7:0]  mem_resp_opaque = '0;
    logic [31:0] mem_resp_data = '0;
    logic        misaligned;

    int   compared = 0, mismatched = 0;
    req_t req_q[$];
    w_t   w_q[$];
    logic [2:0] tag = '0;
    logic [4:0] seq_n = '0;

    load_store_unit_l8 dut (
        .clk(clk), .rst(rst),
        .d_val(d_val), .d_rdy(d_rdy), .d_uop(d_uop), .d_op1(d_op1), .d_op2(d_op2), .d_op3(d_op3),
        .d_seq_num(d_seq_num), .d_waddr(d_waddr), .d_preg(d_preg), .d_ppreg(d_ppreg), .d_pc(d_pc),
        .w_val(w_val), .w_rdy(w_rdy), .w_wdata(w_wdata), .w_wen(w_wen), .w_waddr(w_waddr),
        .w_preg(w_preg), .w_ppreg(w_ppreg), .w_seq_num(w_seq_num), .w_pc(w_pc),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_type(mem_req_type),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_strb(mem_req_strb),
        .mem_req_opaque(mem_req_opaque), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
        .mem_resp_opaque(mem_resp_opaque), .mem_resp_data(mem_resp_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected request (if any) and retirement, then transfers one uop on D.
    task automatic op(input logic [2:0] uo, input logic [31:0] a, b, c, input logic req,
                      input logic [31:0] ra, rd, input logic [3:0] rs,
                      input logic chkd, input logic [31:0] wd, input logic wen, input logic mis);
        req_t r;
        w_t   w;
        r.t = uo >= SB; r.addr = ra; r.data = rd; r.strb = rs; r.opq = {5'b0, tag};
        if (req) req_q.push_back(r);
        w.chkd = chkd; w.wdata = wd; w.wen = wen; w.mis = mis;
        w.meta = {seq_n, 6'(seq_n) + 6'd1, 6'(seq_n) + 6'd2, 32'h1000 + {25'b0, seq_n, 2'b00}};
        w_q.push_back(w);
        d_val = 1'b1; d_uop = uo; d_op1 = a; d_op2 = b; d_op3 = c;
        d_seq_num = seq_n; d_waddr = seq_n; d_preg = 6'(seq_n) + 6'd1; d_ppreg = 6'(seq_n) + 6'd2;
        d_pc = 32'h1000 + {25'b0, seq_n, 2'b00};
        for (int i = 0; i < 50 && !d_rdy; i++) tick();
        chk("d_rdy_wait", d_rdy, 1);
        tick();
        d_val = 1'b0;
        tag++;
        seq_n++;
    endtask

    task automatic resp(input logic [2:0] t, input logic [31:0] d);
        mem_resp_val = 1'b1; mem_resp_opaque = {5'b0, t}; mem_resp_data = d;
        tick();
        mem_resp_val = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && mem_req_val && mem_req_rdy) begin
            chk("req_expected", req_q.size() != 0, 1);
            if (req_q.size() != 0) begin
                req_t r;
                r = req_q.pop_front();
                chk("req_type", mem_req_type, r.t);
                chk("req_addr", mem_req_addr, r.addr);
                chk("req_data", mem_req_data, r.data);
                chk("req_strb", mem_req_strb, r.strb);
                chk("req_opaque", mem_req_opaque, r.opq);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && w_val && w_rdy) begin
            chk("w_expected", w_q.size() != 0, 1);
            if (w_q.size() != 0) begin
                w_t w;
                w = w_q.pop_front();
                chk("w_meta", {w_seq_num, w_preg, w_ppreg, w_pc}, w.meta);
                chk("w_waddr", w_waddr, w.meta[48:44]);
                chk("w_wen", w_wen, w.wen);
                chk("w_misaligned", misaligned, w.mis);
                if (w.chkd) chk("w_wdata", w_wdata, w.wdata);
            end
        end
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_w_val", w_val, 0);
        chk("rst_req_val", mem_req_val, 0);
        chk("rst_d_rdy", d_rdy, 1);
        chk("rst_misaligned", misaligned, 0);
        chk("resp_rdy", mem_resp_rdy, 1);

        // LW, request latency and one-cycle response-to-W latency without bypass
        op(LW, 32'h100, 32'h4, 0, 1, 32'h104, 0, 4'b1111, 1, 32'hDEADBEEF, 1, 0);
        chk("t1_req_latency", mem_req_val, 1);
        tick();
        mem_resp_val = 1'b1; mem_resp_opaque = 8'd0; mem_resp_data = 32'hDEADBEEF;
        chk("t1_no_bypass", w_val, 0);
        tick();
        mem_resp_val = 1'b0;
        chk("t1_w_latency", w_val, 1);
        tick();

        // LB / LBU at byte 3
        op(LB,  32'h100, 32'h3, 0, 1, 32'h100, 0, 4'b1000, 1, 32'hFFFFFF80, 1, 0);
        op(LBU, 32'h100, 32'h3, 0, 1, 32'h100, 0, 4'b1000, 1, 32'h00000080, 1, 0);
        tick();
        resp(3'd1, 32'h80FFFFFF);
        resp(3'd2, 32'h80FFFFFF);

        // out-of-order responses, in-order retirement
        op(LW, 32'h300, 0, 0, 1, 32'h300, 0, 4'b1111, 1, 32'h11111111, 1, 0);
        op(LW, 32'h304, 0, 0, 1, 32'h304, 0, 4'b1111, 1, 32'h22222222, 1, 0);
        op(LW, 32'h308, 0, 0, 1, 32'h308, 0, 4'b1111, 1, 32'h33333333, 1, 0);
        tick();
        resp(3'd5, 32'h33333333);
        chk("t3_hold_a", w_val, 0);
        resp(3'd4, 32'h22222222);
        chk("t3_hold_b", w_val, 0);
        resp(3'd3, 32'h11111111);
        chk("t3_head_ready", w_val, 1);

        // stores
        op(SW, 32'h200, 0, 32'h11223344, 1, 32'h200, 32'h11223344, 4'b1111, 0, 0, 0, 0);
        op(SB, 32'h200, 2, 32'h000000AB, 1, 32'h200, 32'h00AB0000, 4'b0100, 0, 0, 0, 0);
        tick();
        resp(3'd6, 0);
        resp(3'd7, 0);

        // misaligned LW behind an outstanding aligned LW
        op(LW, 32'h100, 0, 0, 1, 32'h100, 0, 4'b1111, 1, 32'h55AA55AA, 1, 0);
`ifdef LSU_L8_ALIGN_CHECK_EN
        op(LW, 32'h100, 2, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
`else
        op(LW, 32'h100, 2, 0, 1, 32'h100, 0, 4'b1100, 0, 0, 1, 0);
`endif
        tick();
        chk("t6_in_order", w_val, 0);
        resp(3'd0, 32'h55AA55AA);
        chk("t6_head_ready", w_val, 1);
`ifndef LSU_L8_ALIGN_CHECK_EN
        resp(3'd1, 32'h12345678);
`endif
        repeat (3) tick();

        // reset with entries in flight and a completed head held by W backpressure
        op(LW, 32'h600, 0, 0, 1, 32'h600, 0, 4'b1111, 0, 0, 1, 0);
        op(LW, 32'h604, 0, 0, 1, 32'h604, 0, 4'b1111, 0, 0, 1, 0);
        op(LW, 32'h608, 0, 0, 1, 32'h608, 0, 4'b1111, 0, 0, 1, 0);
        tick();
        w_rdy = 1'b0;
        resp(3'd2, 32'h0BADF00D);
        chk("t7_pre_w_val", w_val, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_q.delete();
        req_q.delete();
        chk("t7_w_val", w_val, 0);
        chk("t7_d_rdy", d_rdy, 1);
        chk("t7_req_val", mem_req_val, 0);
        w_rdy = 1'b1;
        tag = '0;

        // fill the buffer, hold the 9th uop, then release a slot
        for (int i = 0; i < 8; i++)
            op(LW, 32'h400 + 32'(4 * i), 0, 0, 1, 32'h400 + 32'(4 * i), 0, 4'b1111, 1, 32'hA0000000 + 32'(i), 1, 0);
        tick();
        op(LW, 32'h500, 0, 0, 1, 32'h500, 0, 4'b1111, 1, 32'hBBBBBBBB, 1, 0);
        chk("t4_full_req_val", mem_req_val, 0);
        chk("t4_full_d_rdy", d_rdy, 0);
        tick();
        chk("t4_full_req_val2", mem_req_val, 0);
        chk("t4_full_d_rdy2", d_rdy, 0);
        resp(3'd0, 32'hA0000000);
        chk("t4_drain_cycle_req_val", mem_req_val, 0);
        tick();
        chk("t4_wrap_req_val", mem_req_val, 1);
        chk("t4_wrap_opaque", mem_req_opaque, 0);
        tick();
        for (int i = 1; i < 8; i++) resp(3'(i), 32'hA0000000 + 32'(i));
        resp(3'd0, 32'hBBBBBBBB);

        for (int i = 0; i < 50 && (w_q.size() != 0 || req_q.size() != 0); i++) tick();
        chk("end_w_q_empty", w_q.size(), 0);
        chk("end_req_q_empty", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
